// File: rtl/bin_to_bcd_seq.sv
//------------------------------------------------------------------------------
// Module      : bin_to_bcd_seq
// Description : Sequential double-dabble converter from a signed two's
//               complement operand to packed BCD digits. One shift per clock;
//               results are registered and held until the next conversion.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk         in   1            system clock
//   reset       in   1            asynchronous, active-high reset
//   start       in   1            request conversion of value (sampled in IDLE)
//   value       in   BIN_WIDTH    signed operand
//   busy        out  1            conversion in progress
//   done        out  1            one-cycle pulse, results valid same cycle
//   digits_out  out  4*DIGITS     packed BCD, [3:0] = ones digit
//   negative    out  1            operand was negative
//   overflow    out  1            |value| >= 10^DIGITS (low digits still shown)
//   blank_mask  out  DIGITS       bit i set when digit i is a leading zero
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 32,
  parameter int DIGITS    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic                  negative,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank_mask
);

  // Decimal digits needed to hold 2^BIN_WIDTH (log10(2) ~= 0.302).
  localparam int INT_DIGITS = (BIN_WIDTH * 302) / 1000 + 1;
  // Scratch must also be wide enough to present DIGITS output digits.
  localparam int SCR_DIGITS = (INT_DIGITS > DIGITS) ? INT_DIGITS : DIGITS;
  localparam int SCR_W      = 4 * SCR_DIGITS;
  localparam int CNT_W      = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

  localparam logic [CNT_W-1:0]  c_LAST_STEP = CNT_W'(BIN_WIDTH - 1);
  localparam logic [DIGITS-1:0] c_BLANK_RST = ~(DIGITS'(1));

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [BIN_WIDTH-1:0]  r_mag;
  logic [SCR_W-1:0]      r_scratch;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_sign;

  logic                  r_busy;
  logic                  r_done;
  logic [4*DIGITS-1:0]   r_digits;
  logic                  r_neg;
  logic                  r_ovf;
  logic [DIGITS-1:0]     r_blank;

  logic [BIN_WIDTH-1:0]  w_mag_in;
  logic [SCR_W-1:0]      w_adj;
  logic                  w_ovf;
  logic                  w_allz;
  logic [DIGITS-1:0]     w_blank;

  // Negating the most negative value wraps to itself, which read as unsigned
  // is exactly its magnitude, so no special case is needed.
  assign w_mag_in = value[BIN_WIDTH-1] ? (-value) : value;

  //----------------------------------------------------------------------------
  // FSM state register
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //----------------------------------------------------------------------------
  // FSM next state
  //----------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_SHIFT;
      S_SHIFT:  if (r_cnt == c_LAST_STEP) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  //----------------------------------------------------------------------------
  // Double-dabble correction: any nibble >= 5 gets +3 before the shift so it
  // carries correctly into the next decimal digit.
  //----------------------------------------------------------------------------
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < SCR_DIGITS; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  //----------------------------------------------------------------------------
  // Result decode from the finished scratch: overflow and leading-zero mask
  //----------------------------------------------------------------------------
  always_comb begin
    w_ovf = 1'b0;
    for (int i = DIGITS; i < SCR_DIGITS; i++) begin
      w_ovf = w_ovf | (|r_scratch[4*i +: 4]);
    end
  end

  // Walk down from the top digit; a digit is blank while everything above it
  // (and itself) is zero. The ones digit is never blanked.
  always_comb begin
    w_blank = '0;
    w_allz  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_allz     = w_allz & (r_scratch[4*i +: 4] == 4'd0);
      w_blank[i] = w_allz & ~w_ovf;
    end
  end

  //----------------------------------------------------------------------------
  // Datapath and output registers
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mag     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_sign    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_digits  <= '0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
      r_blank   <= c_BLANK_RST;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mag     <= w_mag_in;
            r_sign    <= value[BIN_WIDTH-1];
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_SHIFT: begin
          // Top bit of the corrected scratch is always zero (scratch is sized
          // for the largest magnitude), so truncating it is safe.
          r_scratch <= SCR_W'({w_adj, r_mag[BIN_WIDTH-1]});
          r_mag     <= r_mag << 1;
          r_cnt     <= r_cnt + CNT_W'(1);
        end
        S_FINISH: begin
          r_digits <= r_scratch[4*DIGITS-1:0];
          r_neg    <= r_sign;
          r_ovf    <= w_ovf;
          r_blank  <= w_blank;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign digits_out = r_digits;
  assign negative   = r_neg;
  assign overflow   = r_ovf;
  assign blank_mask = r_blank;

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
//------------------------------------------------------------------------------
// Module      : tb_bin_to_bcd_seq
// Description : Self-checking bench for bin_to_bcd_seq. Expected results come
//               from an integer-arithmetic reference model pushed to a
//               scoreboard queue at launch and popped on each done pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic [31:0] digits_out;
  logic        negative;
  logic        overflow;
  logic [7:0]  blank_mask;

  typedef struct packed {
    logic [31:0] digits;
    logic        neg;
    logic        ovf;
    logic [7:0]  blank;
  } exp_t;

  typedef struct {
    logic [31:0] v;
    logic [31:0] dig;
    logic        neg;
    logic        ovf;
    logic [7:0]  blank;
  } vec_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_WIDTH(32), .DIGITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .value      (value),
    .busy       (busy),
    .done       (done),
    .digits_out (digits_out),
    .negative   (negative),
    .overflow   (overflow),
    .blank_mask (blank_mask)
  );

  function automatic exp_t model(input logic [31:0] v);
    exp_t   e;
    longint m;
    longint r;
    logic   allz;
    m = longint'($signed(v));
    if (m < 0) m = -m;
    e.neg    = v[31];
    e.ovf    = (m >= 100000000);
    r        = m % 100000000;
    e.digits = '0;
    for (int i = 0; i < 8; i++) begin
      e.digits[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    e.blank = '0;
    allz    = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      allz       = allz && (e.digits[4*i +: 4] == 4'd0);
      e.blank[i] = allz && !e.ovf;
    end
    return e;
  endfunction

  task automatic launch(input logic [31:0] v);
    start = 1'b1;
    value = v;
    sb_q.push_back(model(v));
  endtask

  // Edges counted from the accepting edge (E0) until done is seen; busy
  // counted over the same samples.
  task automatic wait_done(output int edges, output int busy_n);
    @(posedge clk); #1;
    start  = 1'b0;
    edges  = 1;
    busy_n = busy ? 1 : 0;
    while (!done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_n++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL done_timeout: no done after %0d edges, required within 34", edges);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, digits_out, negative, overflow, blank_mask} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'hFE}) begin
      fails++;
      $display("FAIL reset_values: busy=%b done=%b dig=%h neg=%b ovf=%b blank=%h, required 0 0 00000000 0 0 fe",
               busy, done, digits_out, negative, overflow, blank_mask);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero;
    int   edges, bn;
    exp_t e;
    launch(32'd0);
    wait_done(edges, bn);
    tests++;
    if (edges !== 34) begin
      fails++;
      $display("FAIL zero_latency: got %0d edges, required 34", edges);
    end
    e = (sb_q.size() > 0) ? sb_q[0] : '0;
    tests++;
    if (sb_q.size() == 0 || {digits_out, negative, overflow, blank_mask} !== e) begin
      fails++;
      $display("FAIL zero_sb: got %h/%b/%b/%h, required %h/%b/%b/%h",
               digits_out, negative, overflow, blank_mask, e.digits, e.neg, e.ovf, e.blank);
    end
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    tests++;
    if ({digits_out, blank_mask} !== {32'h0, 8'hFE}) begin
      fails++;
      $display("FAIL zero_literal: got dig=%h blank=%h, required 00000000 fe", digits_out, blank_mask);
    end
  endtask

  task automatic test_table;
    vec_t tab[6];
    int   edges, bn;
    exp_t e;
    tab = '{
      '{32'd12345,      32'h00012345, 1'b0, 1'b0, 8'hE0},
      '{32'hFFFFFFFF,   32'h00000001, 1'b1, 1'b0, 8'hFE},
      '{32'd99999999,   32'h99999999, 1'b0, 1'b0, 8'h00},
      '{32'd100000000,  32'h00000000, 1'b0, 1'b1, 8'h00},
      '{32'h80000000,   32'h47483648, 1'b1, 1'b1, 8'h00},
      '{32'd7,          32'h00000007, 1'b0, 1'b0, 8'hFE}
    };
    for (int k = 0; k < 6; k++) begin
      launch(tab[k].v);
      wait_done(edges, bn);
      e = (sb_q.size() > 0) ? sb_q[0] : '0;
      tests++;
      if (sb_q.size() == 0 || {digits_out, negative, overflow, blank_mask} !== e) begin
        fails++;
        $display("FAIL table_sb[%0d]: got %h/%b/%b/%h, required %h/%b/%b/%h", k,
                 digits_out, negative, overflow, blank_mask, e.digits, e.neg, e.ovf, e.blank);
      end
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      tests++;
      if ({digits_out, negative, overflow, blank_mask} !== {tab[k].dig, tab[k].neg, tab[k].ovf, tab[k].blank}) begin
        fails++;
        $display("FAIL table_literal[%0d]: got %h/%b/%b/%h, required %h/%b/%b/%h", k,
                 digits_out, negative, overflow, blank_mask,
                 tab[k].dig, tab[k].neg, tab[k].ovf, tab[k].blank);
      end
      if (k == 0) begin
        tests++;
        if (bn !== 33) begin
          fails++;
          $display("FAIL busy_cycles: got %0d, required 33", bn);
        end
      end
    end
  endtask

  task automatic test_random;
    int          edges, bn;
    exp_t        e;
    logic [31:0] v;
    for (int k = 0; k < 6; k++) begin
      if (k < 3) v = $urandom;
      else begin
        v = 32'($urandom_range(0, 999999));
        if (k == 4) v = -v;
      end
      launch(v);
      wait_done(edges, bn);
      e = (sb_q.size() > 0) ? sb_q[0] : '0;
      tests++;
      if (sb_q.size() == 0 || {digits_out, negative, overflow, blank_mask} !== e) begin
        fails++;
        $display("FAIL random_sb[%0d] v=%h: got %h/%b/%b/%h, required %h/%b/%b/%h", k, v,
                 digits_out, negative, overflow, blank_mask, e.digits, e.neg, e.ovf, e.blank);
      end
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
  endtask

  task automatic test_start_held;
    int   edges = 0;
    int   n_done = 0;
    exp_t e;
    @(posedge clk); #1;
    launch(32'd123456);
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      edges++;
      if (edges <= 20) value = $urandom;
      else start = 1'b0;
      if (done) begin
        n_done++;
        e = (sb_q.size() > 0) ? sb_q[0] : '0;
        tests++;
        if (sb_q.size() == 0 || {digits_out, negative, overflow, blank_mask} !== e) begin
          fails++;
          $display("FAIL held_sb: got %h/%b/%b/%h, required %h/%b/%b/%h",
                   digits_out, negative, overflow, blank_mask, e.digits, e.neg, e.ovf, e.blank);
        end
        if (sb_q.size() > 0) void'(sb_q.pop_front());
      end
    end
    tests++;
    if (n_done !== 1) begin
      fails++;
      $display("FAIL held_done_count: got %0d, required 1", n_done);
    end
  endtask

  task automatic test_back_to_back;
    int   edges, bn;
    exp_t e;
    launch(32'd55555555);
    wait_done(edges, bn);
    e = (sb_q.size() > 0) ? sb_q[0] : '0;
    tests++;
    if (sb_q.size() == 0 || {digits_out, negative, overflow, blank_mask} !== e) begin
      fails++;
      $display("FAIL b2b_first: got %h/%b/%b/%h, required %h/%b/%b/%h",
               digits_out, negative, overflow, blank_mask, e.digits, e.neg, e.ovf, e.blank);
    end
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    // start raised while done is high: must be accepted on the next edge
    launch(32'h80000000);
    wait_done(edges, bn);
    tests++;
    if (edges !== 34 || bn !== 33) begin
      fails++;
      $display("FAIL b2b_timing: got edges=%0d busy=%0d, required 34 33", edges, bn);
    end
    e = (sb_q.size() > 0) ? sb_q[0] : '0;
    tests++;
    if (sb_q.size() == 0 || {digits_out, negative, overflow, blank_mask} !== e) begin
      fails++;
      $display("FAIL b2b_second: got %h/%b/%b/%h, required %h/%b/%b/%h",
               digits_out, negative, overflow, blank_mask, e.digits, e.neg, e.ovf, e.blank);
    end
    if (sb_q.size() > 0) void'(sb_q.pop_front());
  endtask

  task automatic test_reset_mid;
    int n_done = 0;
    @(posedge clk); #1;
    launch(-32'sd9999);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    #1;
    tests++;
    if ({busy, done, digits_out, negative, overflow, blank_mask} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'hFE}) begin
      fails++;
      $display("FAIL midreset_values: busy=%b done=%b dig=%h neg=%b ovf=%b blank=%h, required 0 0 00000000 0 0 fe",
               busy, done, digits_out, negative, overflow, blank_mask);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    tests++;
    if (n_done !== 0) begin
      fails++;
      $display("FAIL midreset_no_done: got %0d done pulses, required 0", n_done);
    end
  endtask

  task automatic test_after_reset;
    int   edges, bn;
    exp_t e;
    launch(-32'sd9876543);
    wait_done(edges, bn);
    tests++;
    if (edges !== 34) begin
      fails++;
      $display("FAIL after_reset_latency: got %0d edges, required 34", edges);
    end
    e = (sb_q.size() > 0) ? sb_q[0] : '0;
    tests++;
    if (sb_q.size() == 0 || {digits_out, negative, overflow, blank_mask} !== e) begin
      fails++;
      $display("FAIL after_reset_sb: got %h/%b/%b/%h, required %h/%b/%b/%h",
               digits_out, negative, overflow, blank_mask, e.digits, e.neg, e.ovf, e.blank);
    end
    if (sb_q.size() > 0) void'(sb_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_zero();
    test_table();
    test_random();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    test_after_reset();
    tests++;
    if (sb_q.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
